// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch unit.
// Source tags, PC region map, fetch FSM states, reset defaults.
package fetch_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IC   = 2'd1,
    SRC_BIOS = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LIVE  = 2'd1,
    HELD  = 2'd2
  } fetch_state_e;

  localparam logic [3:0] REGION_IC   = 4'h1;
  localparam logic [3:0] REGION_BIOS = 4'h4;

  localparam logic [31:0] RESET_PC  = 32'h4000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_src_decode.sv
// fetch_src_decode: maps PC[31:28] to the memory that serves it.
// region_i: PC[31:28]; src_o: IC, BIOS or NONE (unmapped).
module fetch_src_decode
  import fetch_pkg::*;
(
  input  logic [3:0] region_i,
  output src_e       src_o
);

  always_comb begin
    src_o = SRC_NONE;
    unique case (1'b1)
      (region_i == REGION_IC):   src_o = SRC_IC;
      (region_i == REGION_BIOS): src_o = SRC_BIOS;
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, selects I-cache/BIOS read data one cycle
// later, squashes wrong-path fetches on redirect, holds across stalls.
// In: clk, reset_n, stall, redirect, redirect_pc, ic_dout, bios_dout.
// Out: pc_out, instr_out, pc_id, instr_valid, bad_fetch.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] ic_dout,
  input  logic [31:0] bios_dout,
  output logic [31:0] instr_out,
  output logic [31:0] pc_id,
  output logic        instr_valid,
  output logic        bad_fetch
);

  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rsp_pc_q, rsp_pc_d;
  src_e         rsp_src_q, rsp_src_d;
  logic [31:0]  hold_q, hold_d;
  fetch_state_e state_q, state_d;

  src_e        fetch_src;
  logic        issue;
  logic [31:0] live_word;

  fetch_src_decode u_src_decode (
    .region_i (pc_q[31:28]),
    .src_o    (fetch_src)
  );

  // The memory enables are gated by stall in the same cycle.
  assign issue = !stall;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_comb begin
    rsp_pc_d  = rsp_pc_q;
    rsp_src_d = rsp_src_q;
    if (issue) begin
      rsp_pc_d  = pc_q;
      rsp_src_d = fetch_src;
    end
  end

  always_comb begin
    live_word = NOP_INSTR;
    unique case (rsp_src_q)
      SRC_IC:   live_word = ic_dout;
      SRC_BIOS: live_word = bios_dout;
      default:  live_word = NOP_INSTR;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      EMPTY: begin
        if (issue) state_d = LIVE;
      end
      LIVE: begin
        // Memory data is only valid this cycle; latch it before
        // the stall lets the read port go stale.
        if (stall) begin
          state_d = HELD;
          hold_d  = live_word;
        end
      end
      HELD: begin
        if (issue) state_d = LIVE;
      end
      default: state_d = EMPTY;
    endcase
    // The fetch issued alongside a redirect is wrong-path.
    if (redirect) state_d = EMPTY;
  end

  always_comb begin
    instr_out   = NOP_INSTR;
    instr_valid = 1'b0;
    unique case (state_q)
      LIVE: begin
        instr_out   = live_word;
        instr_valid = 1'b1;
      end
      HELD: begin
        instr_out   = hold_q;
        instr_valid = 1'b1;
      end
      default: begin
        instr_out   = NOP_INSTR;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign bad_fetch = instr_valid & (rsp_src_q == SRC_NONE);
  assign pc_out    = pc_q;
  assign pc_id     = rsp_pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      rsp_pc_q  <= '0;
      rsp_src_q <= SRC_NONE;
      hold_q    <= NOP_INSTR;
      state_q   <= EMPTY;
    end else begin
      pc_q      <= pc_d;
      rsp_pc_q  <= rsp_pc_d;
      rsp_src_q <= rsp_src_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch datapath that owns the program counter and turns synchronous memory read data into a decode-ready instruction stream. It drives the PC consumed by the fetch-stage memory-enable decode, which raises the I-cache read enable for PC[31:28]=4'h1 and the BIOS read enable for 4'h4. One cycle later it selects the returned I-cache or BIOS word, squashes wrong-path fetches on redirect, and holds the instruction across stalls. It sits between the PC redirect sources (branch/jump resolution, reset) and the IF/ID boundary.

## Interface
- RESET_PC, 32'h4000_0000, PC loaded at reset (BIOS entry)
- NOP_INSTR, 32'h0000_0000, instruction emitted when no valid fetch is present

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  reset; one clock, asynchronous, active-low
- stall  in  1  pipeline stall; the same signal gates the memory read enables this cycle
- redirect  in  1  load redirect_pc; wins over stall
- redirect_pc  in  32  redirect target, word-aligned
- pc_out  out  32  fetch address issued this cycle (= pc_q)
- ic_dout  in  32  I-cache read data, valid one cycle after its address
- bios_dout  in  32  BIOS read data, valid one cycle after its address
- instr_out  out  32  instruction for decode
- pc_id  out  32  PC of instr_out
- instr_valid  out  1  instr_out is a real fetched instruction
- bad_fetch  out  1  instr_out came from an unmapped PC region (instr_out = NOP_INSTR)

## Operation
- pc_q update, in priority order:
  - redirect → redirect_pc
  - stall → hold
  - otherwise → pc_q+4
  - Adds are modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Fetch issued in a cycle = !stall. Source tag from pc_q[31:28]: 4'h1 → IC, 4'h4 → BIOS, else NONE.
- Response registers rsp_pc and rsp_src load on every issued fetch.
- FSM states:
  - EMPTY: nothing in flight.
  - LIVE: memory data for rsp_pc is on ic_dout/bios_dout this cycle.
  - HELD: instruction is latched in hold_q.
- Transitions (redirect checked first):
  - any state, redirect → EMPTY (the fetch issued this cycle is wrong-path and is dropped)
  - EMPTY: !stall → LIVE; stall → EMPTY
  - LIVE: stall → HELD, capturing the selected word into hold_q; !stall → LIVE
  - HELD: stall → HELD; !stall → LIVE
- Output mux:
  - EMPTY: instr_out = NOP_INSTR, instr_valid = 0
  - LIVE: instr_out = rsp_src IC ? ic_dout : BIOS ? bios_dout : NOP_INSTR
  - HELD: instr_out = hold_q
  - instr_valid = 1 in LIVE/HELD
  - bad_fetch = instr_valid & rsp_src==NONE (hold_q = NOP_INSTR in that case)
  - pc_id = rsp_pc
- Reset values:
  - pc_q = pc_out = RESET_PC
  - state = EMPTY, so instr_valid = 0 and bad_fetch = 0
  - instr_out = NOP_INSTR
  - pc_id, rsp_pc = 0
  - hold_q = NOP_INSTR
- Reset mid-stall or mid-HELD: all of the above, immediately (asynchronous).

## Timing
- Fetch latency: address issued in cycle T → instruction valid in T+1.
- Redirect asserted in T (stalled or not):
  - T+1: pc_out = target, EMPTY, instr_valid = 0
  - T+2: target instruction valid, provided the fetch in T+1 is not stalled
- Stall asserted in T while LIVE:
  - T: output is live memory data
  - T+1 onward: identical instr_out and pc_id from hold_q until the first !stall cycle, inclusive
  - The cycle after release: LIVE with the instruction at the held pc_q
- Stall never changes pc_out. No instruction is duplicated or lost across any stall length ≥1.
- Memory outputs are not relied on while their enables are low; hold_q is the only source during a stall.

## Structure
- Shared package fetch_pkg holds:
  - source enum {SRC_NONE, SRC_IC, SRC_BIOS}
  - region constants 4'h1 / 4'h4
  - FSM state enum {EMPTY, LIVE, HELD}
  - RESET_PC and NOP_INSTR defaults
- One sub-module is natural: fetch_src_decode (pc[31:28] → source tag). The memory-enable decode uses the same mapping and must stay consistent with it.

## Test plan
- Reset release, no stalls:
  - pc_out = 4000_0000, 4000_0004, …
  - instr_valid rises one cycle after release
  - instr_out = bios_dout, pc_id = 4000_0000
- Redirect to 1000_0000 while LIVE:
  - next cycle EMPTY, instr_valid = 0
  - following cycle instr_out = ic_dout, pc_id = 1000_0000
- 3-cycle stall while LIVE at pc_id = 4000_0008, with bios_dout driven to garbage during the stall:
  - instr_out holds the captured word for all stall cycles and the release cycle
  - pc_out stays constant throughout
  - next pc_id = 4000_000C
- Redirect and stall asserted together: pc_out = redirect_pc next cycle; no held instruction appears.
- Fetch from 2000_0000: instr_valid = 1, bad_fetch = 1, instr_out = 0000_0000.
- Asynchronous reset asserted mid-HELD: outputs return to reset values without a clock edge; PC wraps FFFF_FFFC → 0000_0000 (reached via redirect).
